// File: rtl/sfx_pkg.sv
// Shared sizes and FSM state type for the GSU instruction cache controller.
package sfx_pkg;

  localparam int CACHE_BYTES = 512;
  localparam int LINES       = 32;
  localparam int LINE_BYTES  = 16;
  localparam int ROM_AW      = 23;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_RESP,
    ST_FILL_REQ,
    ST_FILL_WAIT,
    ST_UNCACHED
  } state_t;

endpackage

// File: rtl/sfx_cache_valid.sv
// Per-line valid bits: set one line by index, clear all at once, read one line by index.
module sfx_cache_valid #(
  parameter int LINES = 32,
  localparam int LINE_W = $clog2(LINES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [LINE_W-1:0] set_idx,
  input  logic              clr_all,
  input  logic [LINE_W-1:0] rd_idx,
  output logic              rd_valid
);

  logic [LINES-1:0] valid_q;

  // Clear-all wins over a same-cycle set so a flush never leaves a stale line behind.
  always_ff @(posedge clk) begin
    if (rst || clr_all) begin
      valid_q <= '0;
    end else if (set_en) begin
      valid_q[set_idx] <= 1'b1;
    end
  end

  assign rd_valid = valid_q[rd_idx];

endmodule

// File: rtl/sfx_cache_ctrl.sv
// GSU instruction cache controller: serves opcode fetches from the 512-byte cache,
// fills missing 16-byte lines from Game Pak ROM and bypasses the cache outside the CBR window.
module sfx_cache_ctrl
  import sfx_pkg::*;
#(
  parameter int LINES      = 32,
  parameter int LINE_BYTES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [15:0]       fetch_pc,
  input  logic [7:0]        fetch_pbr,
  output logic              fetch_ack,
  output logic [7:0]        fetch_data,
  input  logic              cbr_wr,
  input  logic [15:0]       cbr_in,
  input  logic              flush,
  output logic [15:0]       cbr,
  output logic              busy,
  output logic [8:0]        cache_addr,
  output logic [7:0]        cache_din,
  output logic              cache_we,
  input  logic [7:0]        cache_dout,
  output logic              rom_rd_req,
  output logic [ROM_AW-1:0] rom_rd_addr,
  input  logic              rom_rd_ack,
  input  logic [7:0]        rom_rd_data
);

  localparam int LINE_W = $clog2(LINES);
  localparam int BYTE_W = $clog2(LINE_BYTES);
  localparam int IDX_W  = LINE_W + BYTE_W;

  state_t            state, state_nx;
  logic [15:0]       cbr_q;
  logic              pend_cbr, pend_flush;
  logic [15:0]       pend_cbr_val;
  logic [15:0]       pc_q;
  logic [6:0]        pbr_q;
  logic [IDX_W-1:0]  off_q;
  logic [BYTE_W-1:0] cnt_q;

  logic [15:0] off;
  logic        in_window, line_valid, idle, cmd_any, pend_any, accept, clr_all, valid_set;
  logic        unused_bits;

  assign off       = fetch_pc - cbr_q;
  assign in_window = (off[15:IDX_W] == '0);
  assign idle      = (state == ST_IDLE);
  assign cmd_any   = cbr_wr | flush;
  assign pend_any  = pend_cbr | pend_flush;
  // A fetch arriving alongside a CBR change or flush waits one cycle so it sees the new state.
  assign accept    = idle & fetch_req & ~cmd_any & ~pend_any;
  assign clr_all   = idle & (cmd_any | pend_any);
  assign cbr       = cbr_q;
  assign busy      = ~idle;
  assign unused_bits = ^{fetch_pbr[7], cbr_in[3:0]};

  sfx_cache_valid #(.LINES(LINES)) u_valid (
    .clk      (clk),
    .rst      (rst),
    .set_en   (valid_set),
    .set_idx  (off_q[IDX_W-1:BYTE_W]),
    .clr_all  (clr_all),
    .rd_idx   (off[IDX_W-1:BYTE_W]),
    .rd_valid (line_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      cbr_q        <= '0;
      pend_cbr     <= 1'b0;
      pend_flush   <= 1'b0;
      pend_cbr_val <= '0;
      pc_q         <= '0;
      pbr_q        <= '0;
      off_q        <= '0;
      cnt_q        <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        pc_q  <= fetch_pc;
        pbr_q <= fetch_pbr[6:0];
        off_q <= off[IDX_W-1:0];
        cnt_q <= '0;
      end else if (state == ST_FILL_REQ && rom_rd_ack) begin
        cnt_q <= cnt_q + BYTE_W'(1);
      end
      // Commands seen while busy are held until the FSM is back in IDLE.
      if (idle) begin
        pend_cbr   <= 1'b0;
        pend_flush <= 1'b0;
        if (cbr_wr) begin
          cbr_q <= {cbr_in[15:4], 4'h0};
        end else if (pend_cbr) begin
          cbr_q <= pend_cbr_val;
        end
      end else begin
        if (cbr_wr) begin
          pend_cbr     <= 1'b1;
          pend_cbr_val <= {cbr_in[15:4], 4'h0};
        end
        if (flush) begin
          pend_flush <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_nx    = state;
    fetch_ack   = 1'b0;
    fetch_data  = '0;
    cache_addr  = '0;
    cache_din   = '0;
    cache_we    = 1'b0;
    rom_rd_req  = 1'b0;
    rom_rd_addr = '0;
    valid_set   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (!in_window) begin
            state_nx = ST_UNCACHED;
          end else if (line_valid) begin
            state_nx = ST_LOOKUP;
          end else begin
            state_nx = ST_FILL_REQ;
          end
        end
      end
      ST_LOOKUP: begin
        cache_addr = off_q;
        state_nx   = ST_RESP;
      end
      ST_RESP: begin
        cache_addr = off_q;
        fetch_ack  = 1'b1;
        fetch_data = cache_dout;
        state_nx   = ST_IDLE;
      end
      ST_FILL_REQ: begin
        rom_rd_req  = 1'b1;
        rom_rd_addr = {pbr_q, pc_q[15:BYTE_W], cnt_q};
        if (rom_rd_ack) begin
          cache_we   = 1'b1;
          cache_addr = {off_q[IDX_W-1:BYTE_W], cnt_q};
          cache_din  = rom_rd_data;
          // A line filled across a flush or CBR change must stay invalid.
          if (&cnt_q) begin
            valid_set = ~(pend_any | cmd_any);
            state_nx  = ST_LOOKUP;
          end else begin
            state_nx = ST_FILL_WAIT;
          end
        end
      end
      ST_FILL_WAIT: begin
        state_nx = ST_FILL_REQ;
      end
      ST_UNCACHED: begin
        rom_rd_req  = 1'b1;
        rom_rd_addr = {pbr_q, pc_q};
        if (rom_rd_ack) begin
          fetch_ack  = 1'b1;
          fetch_data = rom_rd_data;
          state_nx   = ST_IDLE;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sfx_cache_ctrl.sv
// Self-checking bench for sfx_cache_ctrl: directed plan plus random fetches against a line-level cache model.
module tb_sfx_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_req = 1'b0;
  logic [15:0] fetch_pc = '0;
  logic [7:0]  fetch_pbr = '0;
  logic        fetch_ack;
  logic [7:0]  fetch_data;
  logic        cbr_wr = 1'b0;
  logic [15:0] cbr_in = '0;
  logic        flush = 1'b0;
  logic [15:0] cbr;
  logic        busy;
  logic [8:0]  cache_addr;
  logic [7:0]  cache_din;
  logic        cache_we;
  logic [7:0]  cache_dout;
  logic        rom_rd_req;
  logic [22:0] rom_rd_addr;
  logic        rom_rd_ack = 1'b0;
  logic [7:0]  rom_rd_data = '0;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  cache_mem [512];
  logic [22:0] rom_log [$];
  logic [8:0]  cw_log [$];

  logic [15:0] ref_cbr = '0;
  logic [31:0] ref_valid = '0;
  logic [7:0]  ref_cache [512];

  int          wait_left = 0;
  logic        waiting = 1'b0;
  logic [22:0] held_addr = '0;

  sfx_cache_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_req   (fetch_req),
    .fetch_pc    (fetch_pc),
    .fetch_pbr   (fetch_pbr),
    .fetch_ack   (fetch_ack),
    .fetch_data  (fetch_data),
    .cbr_wr      (cbr_wr),
    .cbr_in      (cbr_in),
    .flush       (flush),
    .cbr         (cbr),
    .busy        (busy),
    .cache_addr  (cache_addr),
    .cache_din   (cache_din),
    .cache_we    (cache_we),
    .cache_dout  (cache_dout),
    .rom_rd_req  (rom_rd_req),
    .rom_rd_addr (rom_rd_addr),
    .rom_rd_ack  (rom_rd_ack),
    .rom_rd_data (rom_rd_data)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_byte(input logic [22:0] a);
    return a[7:0] ^ {a[12:8], a[15:13]} ^ {a[22:16], 1'b1} ^ 8'h3C;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, got, exp);
    end
  endtask

  // Dual-port cache RAM stand-in, port A only: synchronous read, one-cycle latency.
  always @(posedge clk) begin
    if (cache_we === 1'b1) begin
      cache_mem[cache_addr] <= cache_din;
      cw_log.push_back(cache_addr);
    end
    cache_dout <= cache_mem[cache_addr];
  end

  // ROM arbiter stand-in: random 0..3 cycle ack latency, one-cycle ack pulse.
  always @(posedge clk) begin
    #1;
    if (rom_rd_ack) begin
      rom_rd_ack = 1'b0;
      check_output("req_drop_after_ack", rom_rd_req, 1'b0);
    end else if (rom_rd_req === 1'b1) begin
      if (!waiting) begin
        waiting   = 1'b1;
        wait_left = $urandom_range(0, 3);
        held_addr = rom_rd_addr;
      end else begin
        check_output("req_addr_stable", rom_rd_addr, held_addr);
      end
      if (wait_left == 0) begin
        rom_rd_ack  = 1'b1;
        rom_rd_data = rom_byte(rom_rd_addr);
        rom_log.push_back(rom_rd_addr);
        waiting = 1'b0;
      end else begin
        wait_left--;
      end
    end else begin
      waiting = 1'b0;
    end
  end

  task automatic apply_reset();
    rst = 1'b1;
    fetch_req = 1'b0;
    cbr_wr = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    ref_cbr = '0;
    ref_valid = '0;
  endtask

  // kind: 1 = flush, 2 = cbr_wr, 3 = both (behaves as cbr_wr).
  task automatic apply_stimulus_cmd(input int kind, input logic [15:0] val);
    @(negedge clk);
    cbr_wr = (kind >= 2);
    flush  = (kind != 2);
    cbr_in = val;
    @(negedge clk);
    cbr_wr = 1'b0;
    flush  = 1'b0;
    ref_valid = '0;
    if (kind >= 2) ref_cbr = {val[15:4], 4'h0};
    check_output("idle_cmd_cbr", cbr, ref_cbr);
  endtask

  // One fetch; optionally fires a command once cmd_at ROM bytes have been returned.
  task automatic apply_stimulus_fetch(input logic [15:0] pc, input logic [7:0] pbr, input int cmd_kind,
                                      input int cmd_at, input logic [15:0] cmd_val, input string tag);
    logic [15:0] off;
    logic [15:0] base;
    logic [4:0]  line;
    logic [22:0] a;
    logic [7:0]  exp_data;
    logic [22:0] exp_addr [$];
    logic [8:0]  exp_idx [$];
    int          kind;
    int          cycles;
    bit          acked;
    bit          fired;
    off  = pc - ref_cbr;
    line = off[8:4];
    exp_addr = {};
    exp_idx  = {};
    if (off[15:9] != 7'd0) begin
      kind = 2;
      a = {pbr[6:0], pc};
      exp_addr.push_back(a);
      exp_data = rom_byte(a);
    end else if (ref_valid[line]) begin
      kind = 0;
      exp_data = ref_cache[off[8:0]];
    end else begin
      kind = 1;
      base = pc & 16'hFFF0;
      for (int k = 0; k < 16; k++) begin
        a = {pbr[6:0], 16'(base + 16'(k))};
        exp_addr.push_back(a);
        exp_idx.push_back({line, 4'(k)});
        ref_cache[{line, 4'(k)}] = rom_byte(a);
      end
      exp_data = ref_cache[off[8:0]];
    end

    rom_log.delete();
    cw_log.delete();
    fetch_pc  = pc;
    fetch_pbr = pbr;
    fetch_req = 1'b1;
    cycles = 0;
    acked  = 0;
    fired  = 0;
    while (!acked && cycles < 400) begin
      @(negedge clk);
      cycles++;
      cbr_wr = 1'b0;
      flush  = 1'b0;
      if (fetch_ack === 1'b1) begin
        acked = 1;
        check_output({tag, ":data"}, fetch_data, exp_data);
        if (kind == 2) check_output({tag, ":unc_ack_with_rom_ack"}, rom_rd_ack, 1'b1);
        if (kind == 0) check_output({tag, ":hit_latency"}, cycles, 2);
      end else if (cmd_kind != 0 && !fired && rom_log.size() >= cmd_at) begin
        fired  = 1;
        cbr_wr = (cmd_kind >= 2);
        flush  = (cmd_kind != 2);
        cbr_in = cmd_val;
      end
    end
    fetch_req = 1'b0;
    if (!acked) begin
      check_output({tag, ":timeout"}, 1'b0, 1'b1);
      apply_reset();
      return;
    end

    check_output({tag, ":rom_reads"}, rom_log.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size() && i < rom_log.size(); i++)
      check_output({tag, ":rom_addr"}, rom_log[i], exp_addr[i]);
    check_output({tag, ":cache_writes"}, cw_log.size(), exp_idx.size());
    for (int i = 0; i < exp_idx.size() && i < cw_log.size(); i++)
      check_output({tag, ":cache_idx"}, cw_log[i], exp_idx[i]);

    @(negedge clk);
    check_output({tag, ":single_ack"}, fetch_ack, 1'b0);
    check_output({tag, ":idle_busy"}, busy, 1'b0);
    if (kind == 1 && !fired) ref_valid[line] = 1'b1;
    if (fired) begin
      ref_valid = '0;
      if (cmd_kind >= 2) ref_cbr = {cmd_val[15:4], 4'h0};
    end
    @(negedge clk);
    check_output({tag, ":cbr_after"}, cbr, ref_cbr);
  endtask

  initial begin
    $display("[TB] sfx_cache_ctrl bench starting");
    apply_reset();
    check_output("rst:fetch_ack", fetch_ack, 1'b0);
    check_output("rst:fetch_data", fetch_data, 8'h00);
    check_output("rst:cache_we", cache_we, 1'b0);
    check_output("rst:cache_addr", cache_addr, 9'h000);
    check_output("rst:cache_din", cache_din, 8'h00);
    check_output("rst:rom_rd_req", rom_rd_req, 1'b0);
    check_output("rst:rom_rd_addr", rom_rd_addr, 23'h0);
    check_output("rst:busy", busy, 1'b0);
    check_output("rst:cbr", cbr, 16'h0000);

    apply_stimulus_cmd(2, 16'h8005);
    check_output("cbr_low_nibble_forced", cbr, 16'h8000);
    apply_stimulus_fetch(16'h8013, 8'h00, 0, 0, 16'h0, "miss_line1");
    apply_stimulus_fetch(16'h801F, 8'h00, 0, 0, 16'h0, "hit_801f");
    apply_stimulus_fetch(16'h8200, 8'h00, 0, 0, 16'h0, "uncached_8200");

    apply_stimulus_cmd(1, 16'h0000);
    apply_stimulus_fetch(16'h8013, 8'h00, 1, 7, 16'h0, "flush_mid_fill");
    apply_stimulus_fetch(16'h8013, 8'h00, 0, 0, 16'h0, "refill_line1");

    rom_log.delete();
    fetch_pc  = 16'h8023;
    fetch_pbr = 8'h00;
    fetch_req = 1'b1;
    for (int i = 0; i < 200 && rom_log.size() < 3; i++) @(negedge clk);
    for (int i = 0; i < 10 && rom_rd_req !== 1'b1; i++) @(negedge clk);
    check_output("rst_mid_fill:req_high", rom_rd_req, 1'b1);
    rst = 1'b1;
    fetch_req = 1'b0;
    @(negedge clk);
    check_output("rst_mid_fill:req", rom_rd_req, 1'b0);
    check_output("rst_mid_fill:busy", busy, 1'b0);
    check_output("rst_mid_fill:cbr", cbr, 16'h0000);
    check_output("rst_mid_fill:ack", fetch_ack, 1'b0);
    rst = 1'b0;
    ref_cbr = '0;
    ref_valid = '0;
    @(negedge clk);
    apply_stimulus_fetch(16'h0000, 8'h00, 0, 0, 16'h0, "miss_line0_after_rst");

    apply_stimulus_cmd(1, 16'h0000);
    apply_stimulus_fetch(16'h0004, 8'hFF, 0, 0, 16'h0, "pbr_bit7_dropped");
    apply_stimulus_fetch(16'hFFFF, 8'h12, 0, 0, 16'h0, "uncached_ffff");

    for (int it = 0; it < 40; it++) begin
      int          ck;
      int          ca;
      logic [15:0] pc;
      if ($urandom_range(0, 5) == 0) apply_stimulus_cmd(int'($urandom_range(1, 3)), 16'($urandom));
      pc = ref_cbr + 16'($urandom_range(0, 639));
      ck = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      ca = int'($urandom_range(0, 16));
      apply_stimulus_fetch(pc, 8'($urandom), ck, ca, 16'($urandom), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sfx_cache_ctrl.md
# sfx_cache_ctrl

Controller for the GSU's 512-byte instruction cache (`sfx_cache`, dual-port 512×8). It does three things:
- serves opcode fetches from the core's fetch stage;
- tracks per-line valid bits for 32 lines of 16 bytes, relative to CBR;
- on a miss, sequences 16-byte line fills from Game Pak ROM through a byte-wide request/acknowledge port.

Fetches outside the cache window bypass the cache and read ROM directly. The block sits between the core pipeline, cache port A and the ROM bus arbiter.

## Interface
Parameters:
- LINES, 32: number of cache lines.
- LINE_BYTES, 16: bytes per line.

Ports:
- clk  in  1  GSU core clock. Single clock domain.
- rst  in  1  Synchronous, active-high reset.
- fetch_req  in  1  Fetch request. Held high until fetch_ack.
- fetch_pc  in  16  R15. Stable while fetch_req is high.
- fetch_pbr  in  8  PBR. Stable while fetch_req is high.
- fetch_ack  out  1  One-cycle pulse; fetch_data valid in the same cycle.
- fetch_data  out  8  Fetched opcode byte.
- cbr_wr  in  1  Pulse: load CBR from cbr_in and flush.
- cbr_in  in  16  New CBR. Bits [3:0] are ignored and forced to 0.
- flush  in  1  Pulse: invalidate all lines (CACHE instruction, or GO cleared).
- cbr  out  16  Current CBR.
- busy  out  1  High whenever state ≠ IDLE.
- cache_addr  out  9  Cache port A address.
- cache_din  out  8  Cache port A write data.
- cache_we  out  1  Cache port A write enable.
- cache_dout  in  8  Cache port A read data. Valid 1 cycle after the address is presented.
- rom_rd_req  out  1  ROM byte read request. Held until rom_rd_ack.
- rom_rd_addr  out  23  {pbr[6:0], addr[15:0]}.
- rom_rd_ack  in  1  One-cycle pulse; rom_rd_data valid in the same cycle.
- rom_rd_data  in  8  ROM byte.

## Operation
- Window test: `off = fetch_pc − cbr` (16-bit, wrapping). Hit window iff `off[15:9] == 0`. Line = `off[8:4]`, byte = `off[3:0]`. Cache index = `off[8:0]`.
- States:
  - IDLE: on fetch_req, capture pc/pbr/off.
    - In window and line valid → LOOKUP.
    - In window and line invalid → FILL_REQ with fill counter = 0.
    - Out of window → UNCACHED.
  - LOOKUP: drive `cache_addr = off[8:0]` → RESP.
  - RESP: `fetch_ack = 1`, `fetch_data = cache_dout` → IDLE.
  - FILL_REQ/FILL_WAIT: `rom_rd_req = 1` with address `{pbr[6:0], (pc & 16'hFFF0) + cnt}`.
    - On rom_rd_ack: write the byte to cache index `{line, cnt}` with `cache_we = 1` for one cycle, then cnt++.
    - After cnt = 15 is written: set valid[line] → LOOKUP.
  - UNCACHED: rom_rd_req at `{pbr[6:0], pc}`. On rom_rd_ack: `fetch_ack = 1`, `fetch_data = rom_rd_data` → IDLE. No cache write.
- ROM address low half wraps at 16 bits within the bank. No carry into pbr.
- cbr_wr and flush arriving in IDLE take effect next cycle:
  - all valid bits are cleared;
  - on cbr_wr, `cbr ← {cbr_in[15:4], 4'h0}`.
- cbr_wr and flush arriving while busy are latched as pending and applied on the cycle the FSM returns to IDLE. The in-flight fetch completes with its data, and the line being filled is not marked valid. A fetch_req in that same IDLE cycle is evaluated against the updated state one cycle later.
- cbr_wr and flush in the same cycle: treated as cbr_wr.
- Valid bits are not cleared by wrap of `off`.

## Timing
- Reset values:
  - outputs: fetch_ack = 0, fetch_data = 0, cache_we = 0, cache_addr = 0, cache_din = 0, rom_rd_req = 0, rom_rd_addr = 0, busy = 0, cbr = 0;
  - internal: valid = 0, pending flags = 0, state = IDLE.
- Hit: fetch_req sampled at cycle 0 → fetch_ack at cycle 2.
- Miss: 16 ROM transactions, each 1 + (ack latency) cycles, followed by LOOKUP/RESP (2 cycles).
- Uncached: fetch_ack in the same cycle as rom_rd_ack.
- rom_rd_req rises at most one cycle after entering a request state. It stays high with a stable address until ack, and drops the cycle after ack.
- rst mid-fill: rom_rd_req drops the following cycle, the partial line is left invalid, and no fetch_ack is issued. The arbiter must tolerate an abandoned request.
- fetch_ack is never asserted twice for one request. A new fetch_req is accepted only in IDLE.

## Structure
- Shared package `sfx_pkg` holds:
  - state enum;
  - CACHE_BYTES = 512, LINES, LINE_BYTES;
  - ROM address width = 23.
- One natural sub-module: `sfx_cache_valid`, a 32-bit valid vector with set-by-index, clear-all and read-by-index.

## Test plan
- Reset, cbr_wr cbr_in = 16'h8005, fetch pc = 16'h8013 → cbr = 16'h8000. Miss on line 1: 16 ROM reads at 0x008010..0x00801F, cache writes to idx 0x010..0x01F, then fetch_ack with the byte written at idx 0x013.
- Repeat fetch at pc = 16'h801F → no rom_rd_req; fetch_ack exactly 2 cycles after fetch_req.
- Fetch pc = 16'h8200 with cbr = 16'h8000 (off = 0x200) → uncached read at 0x008200 with pbr = 0. fetch_data = rom_rd_data; no cache_we.
- flush pulse asserted mid-fill at cnt = 7 → fill completes and the fetch is acked. Line 1 is then invalid, so a refetch at 16'h8013 issues 16 new ROM reads.
- rst asserted while rom_rd_req is high → next cycle rom_rd_req = 0, busy = 0, cbr = 0. A subsequent fetch at pc = 16'h0000 misses line 0.
- pbr = 8'hFF, pc = 16'h0004, cbr = 0 → fill addresses 0x7F0000..0x7F000F (pbr[7] dropped).
